// File: rtl/eq_arb_pkg.sv
// Shared types and default sizing for the equality-compare arbiter slice.
package eq_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPARE = 2'd2,
        RESPOND = 2'd3
    } arb_state_e;

endpackage : eq_arb_pkg

// File: rtl/bit_equality.sv
// Unsigned full-width equality comparator shared by all requesters.
module bit_equality #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             z
);

    assign z = (a == b);

endmodule : bit_equality

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] winner,
    output logic [ID_W-1:0]    winner_idx
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Offsets 1..NUM_REQ visit rr_ptr last, giving it the lowest priority.
    always_comb begin
        any        = 1'b0;
        winner     = '0;
        winner_idx = '0;
        sum        = '0;
        idx        = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                winner     = NUM_REQ'(1) << idx;
                winner_idx = idx;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/eq_compare_arbiter.sv
// Round-robin sharing of one equality comparator among NUM_REQ requesters,
// returning a tagged result over a valid/ready response port.
module eq_compare_arbiter
    import eq_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_flat,
    input  logic [NUM_REQ*WIDTH-1:0] b_flat,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_eq
);

    arb_state_e          state_q, state_d;
    logic [WIDTH-1:0]    op_a_q, op_a_d;
    logic [WIDTH-1:0]    op_b_q, op_b_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  grant_d;
    logic                busy_d;
    logic                rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_d;
    logic                rsp_eq_d;

    logic                win_any;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [ID_W-1:0]     win_idx;
    logic [WIDTH-1:0]    sel_a;
    logic [WIDTH-1:0]    sel_b;
    logic                eq_z;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .any        (win_any),
        .winner     (win_onehot),
        .winner_idx (win_idx)
    );

    bit_equality #(
        .WIDTH (WIDTH)
    ) u_bit_equality (
        .a (op_a_q),
        .b (op_b_q),
        .z (eq_z)
    );

    // Operand mux driven by the one-hot winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                sel_a = a_flat[i*WIDTH +: WIDTH];
                sel_b = b_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            id_q      <= '0;
            rr_ptr_q  <= ID_W'(NUM_REQ - 1);
            grant     <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_eq    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            id_q      <= id_d;
            rr_ptr_q  <= rr_ptr_d;
            grant     <= grant_d;
            busy      <= busy_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_eq    <= rsp_eq_d;
        end
    end

    // Next state and next registered outputs; grant defaults low so it pulses once.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = '0;
        busy_d      = busy;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_eq_d    = rsp_eq;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    op_a_d  = sel_a;
                    op_b_d  = sel_b;
                    id_d    = win_idx;
                    grant_d = win_onehot;
                    busy_d  = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = COMPARE;
            end
            COMPARE: begin
                rsp_eq_d    = eq_z;
                rsp_id_d    = id_q;
                rr_ptr_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESPOND;
            end
            RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : eq_compare_arbiter
